// File: rtl/lcd_pkg.sv
// ============================================================================
// lcd_pkg : shared types and constants for the LCD text streamer
// Rev 1.0
// ============================================================================
`default_nettype none

package lcd_pkg;

  localparam int LCD_COLS = 16;

  localparam logic [7:0] LCD_CMD_ROW0   = 8'h80;
  localparam logic [7:0] LCD_CMD_ROW1   = 8'hC0;
  localparam logic [7:0] LCD_CHAR_SPACE = 8'h20;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_word_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR0 = 3'd1,
    ST_ROW0  = 3'd2,
    ST_ADDR1 = 3'd3,
    ST_ROW1  = 3'd4,
    ST_DONE  = 3'd5
  } lcd_state_t;

  function automatic lcd_word_t lcd_cmd(input logic [7:0] b);
    lcd_word_t w;
    w.rs   = 1'b0;
    w.data = b;
    return w;
  endfunction

  function automatic lcd_word_t lcd_char(input logic [7:0] b);
    lcd_word_t w;
    w.rs   = 1'b1;
    w.data = b;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_tick_gen.sv
// ============================================================================
// lcd_tick_gen : divider emitting a one-cycle tick every PERIOD enabled cycles
// Rev 1.0
// ============================================================================
`default_nettype none

module lcd_tick_gen #(
  parameter int PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Dropping en clears the count so the next enabled period starts fresh.
  always_comb begin
    cnt_d = '0;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_text_streamer.sv
// ============================================================================
// lcd_text_streamer : 2x16 frame buffer streamed as {RS,byte} words to the
//                     HD44780 write engine, with optional row-0 marquee
// Rev 1.0
// ============================================================================
`default_nettype none

module lcd_text_streamer
  import lcd_pkg::*;
#(
  parameter int REFRESH_CYCLES = 5_000_000,
  parameter int SCROLL_CYCLES  = 12_500_000
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic       refresh_req,
  input  logic       scroll_en,
  output logic       out_valid,
  output logic [8:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [4:0] LAST_POS = 5'(LCD_COLS - 1);

  logic refresh_tick;
  logic scroll_tick;

  lcd_tick_gen #(.PERIOD(REFRESH_CYCLES)) u_refresh_tick (
    .clk   (CLOCK_50),
    .rst_n (RST_N),
    .en    (1'b1),
    .tick  (refresh_tick)
  );

  lcd_tick_gen #(.PERIOD(SCROLL_CYCLES)) u_scroll_tick (
    .clk   (CLOCK_50),
    .rst_n (RST_N),
    .en    (scroll_en),
    .tick  (scroll_tick)
  );

  lcd_state_t state_q, state_d;
  logic [4:0] pos_q, pos_d;
  logic [3:0] off_q, off_d;
  logic [3:0] snap_q, snap_d;
  logic       pending_q, pending_d;
  logic       out_valid_q, out_valid_d;
  lcd_word_t  out_data_q, out_data_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;
  logic [7:0] buf_q [32];
  logic [7:0] buf_d [32];

  logic       trigger;
  logic       accept;
  logic [3:0] row0_next_idx;
  logic [3:0] row1_next_idx;

  assign trigger       = refresh_req | refresh_tick;
  assign accept        = out_valid_q & out_ready;
  assign row0_next_idx = pos_q[3:0] + snap_q + 4'd1;
  assign row1_next_idx = pos_q[3:0] + 4'd1;

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    off_d        = off_q;
    snap_d       = snap_q;
    pending_d    = pending_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    buf_d        = buf_q;

    if (wr_en) begin
      buf_d[wr_addr] = wr_char;
    end

    if (!scroll_en) begin
      off_d = 4'd0;
    end else if (scroll_tick) begin
      off_d = off_q + 4'd1;
    end

    // Any number of triggers during a frame collapse into one queued frame.
    if (trigger && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end

    // Words are loaded from buf_q, so a same-edge write is seen by the next load only.
    unique case (state_q)
      ST_IDLE: begin
        if (trigger || pending_q) begin
          state_d     = ST_ADDR0;
          out_valid_d = 1'b1;
          out_data_d  = lcd_cmd(LCD_CMD_ROW0);
          busy_d      = 1'b1;
          pending_d   = 1'b0;
          snap_d      = off_q;
        end
      end
      ST_ADDR0: begin
        if (accept) begin
          state_d    = ST_ROW0;
          pos_d      = 5'd0;
          out_data_d = lcd_char(buf_q[{1'b0, snap_q}]);
        end
      end
      ST_ROW0: begin
        if (accept) begin
          if (pos_q == LAST_POS) begin
            state_d    = ST_ADDR1;
            out_data_d = lcd_cmd(LCD_CMD_ROW1);
          end else begin
            pos_d      = pos_q + 5'd1;
            out_data_d = lcd_char(buf_q[{1'b0, row0_next_idx}]);
          end
        end
      end
      ST_ADDR1: begin
        if (accept) begin
          state_d    = ST_ROW1;
          pos_d      = 5'd0;
          out_data_d = lcd_char(buf_q[5'd16]);
        end
      end
      ST_ROW1: begin
        if (accept) begin
          if (pos_q == LAST_POS) begin
            state_d      = ST_DONE;
            out_valid_d  = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            pos_d      = pos_q + 5'd1;
            out_data_d = lcd_char(buf_q[{1'b1, row1_next_idx}]);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      pos_q        <= 5'd0;
      off_q        <= 4'd0;
      snap_q       <= 4'd0;
      pending_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        buf_q[i] <= LCD_CHAR_SPACE;
      end
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      off_q        <= off_d;
      snap_q       <= snap_d;
      pending_q    <= pending_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      buf_q        <= buf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_text_streamer.sv
// ============================================================================
// tb_lcd_text_streamer : randomized handshake bench with a frame-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lcd_text_streamer;

  localparam int REFRESH = 200;
  localparam int SCROLL  = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_char = '0;
  logic       refresh_req = 1'b0;
  logic       scroll_en = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [8:0] out_data;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int failures = 0;

  logic [7:0] mbuf [32];

  // Marquee model: offset = (cycles with scroll_en held) / SCROLL, mod 16.
  int sc_edges = 0;
  int k_before = 0;

  lcd_text_streamer #(
    .REFRESH_CYCLES (REFRESH),
    .SCROLL_CYCLES  (SCROLL)
  ) dut (
    .CLOCK_50    (clk),
    .RST_N       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_char     (wr_char),
    .refresh_req (refresh_req),
    .scroll_en   (scroll_en),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_edges <= 0;
      k_before <= 0;
    end else begin
      k_before <= (sc_edges / SCROLL) % 16;
      sc_edges <= scroll_en ? sc_edges + 1 : 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
  endtask

  task automatic write_char(input int addr, input logic [7:0] ch);
    wr_en   = 1'b1;
    wr_addr = 5'(addr);
    wr_char = ch;
    mbuf[addr] = ch;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic write_str(input int base, input string s);
    for (int i = 0; i < s.len(); i++) write_char(base + i, s[i]);
  endtask

  task automatic drain();
    int idle_run = 0;
    int budget = 0;
    out_ready = 1'b1;
    while (idle_run < 3 && budget < 600) begin
      @(negedge clk);
      budget++;
      idle_run = (!busy && !out_valid) ? idle_run + 1 : 0;
    end
    if (idle_run < 3) check("drain_idle", 32'(idle_run), 32'd3);
  endtask

  // Collects one frame with randomized out_ready and checks it against the model.
  task automatic collect_frame(input bit do_req, input int rdy_pct, input int wr_at,
                               input int wa, input logic [7:0] wc,
                               input int req_lo, input int req_hi, input string tag);
    logic [8:0] exp_w [34];
    logic [8:0] prev;
    int         k;
    int         j;
    int         waited;
    int         budget;
    bit         have_prev;
    bit         rdy;

    if (do_req) refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
    if (do_req) check({tag, "_latency"}, 32'(out_valid), 32'd1);
    waited = 0;
    while (!out_valid && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) begin
      check({tag, "_start"}, 32'(out_valid), 32'd1);
      return;
    end

    k = k_before;
    exp_w[0]  = 9'h080;
    exp_w[17] = 9'h0C0;
    for (int i = 0; i < 16; i++) begin
      exp_w[1 + i]  = {1'b1, mbuf[(i + k) % 16]};
      exp_w[18 + i] = {1'b1, (wr_at >= 0 && wa == 16 + i) ? wc : mbuf[16 + i]};
    end

    j = 0;
    budget = 0;
    have_prev = 1'b0;
    prev = '0;
    while (j < 34 && budget < 3000) begin
      if (have_prev) begin
        check($sformatf("%s_hold_valid", tag), 32'(out_valid), 32'd1);
        check($sformatf("%s_hold_data", tag), 32'(out_data), 32'(prev));
      end else if (j > 0) begin
        check($sformatf("%s_next_valid_w%0d", tag, j), 32'(out_valid), 32'd1);
      end
      refresh_req = (j >= req_lo && j < req_hi);
      wr_en = 1'b0;
      if (out_valid) begin
        rdy = ($urandom_range(99) < rdy_pct);
        out_ready = rdy;
        if (rdy) begin
          check($sformatf("%s_w%0d", tag, j), 32'(out_data), 32'(exp_w[j]));
          j++;
          have_prev = 1'b0;
          if (j == wr_at) begin
            wr_en   = 1'b1;
            wr_addr = 5'(wa);
            wr_char = wc;
            mbuf[wa] = wc;
          end
        end else begin
          have_prev = 1'b1;
          prev = out_data;
        end
      end else begin
        out_ready = 1'($urandom_range(1));
        have_prev = 1'b0;
      end
      @(negedge clk);
      budget++;
    end
    wr_en = 1'b0;
    refresh_req = 1'b0;
    out_ready = 1'b1;
    if (j < 34) check({tag, "_transfers"}, 32'(j), 32'd34);

    check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_done_pulse"}, 32'(frame_done), 32'd1);
    check({tag, "_done_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(frame_done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset_model();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'h000);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;

    // Automatic frame from the refresh timer with a blank buffer.
    repeat (100) @(negedge clk);
    check("t1_quiet", 32'(out_valid), 32'd0);
    collect_frame(1'b0, 100, -1, 0, 8'h00, -1, -1, "t1");

    // Text content on both rows.
    drain();
    write_str(0, "LE MINH TRI");
    write_str(16, "MSSV");
    drain();
    collect_frame(1'b1, 100, -1, 0, 8'h00, -1, -1, "t2");

    // Back-pressure: out_ready ~30%.
    drain();
    collect_frame(1'b1, 30, -1, 0, 8'h00, -1, -1, "t3");

    // Marquee over several frames, long enough to wrap the offset.
    drain();
    for (int i = 0; i < 16; i++) write_char(i, 8'h41 + 8'(i));
    scroll_en = 1'b1;
    for (int n = 0; n < 10; n++) begin
      repeat ($urandom_range(200, 60)) @(negedge clk);
      drain();
      collect_frame(1'b1, 100, -1, 0, 8'h00, -1, -1, $sformatf("t4_f%0d", n));
    end
    scroll_en = 1'b0;
    @(negedge clk);
    drain();
    collect_frame(1'b1, 100, -1, 0, 8'h00, -1, -1, "t4_off");

    // Triggers mid-frame queue exactly one more frame; mid-frame write shows in row 1.
    drain();
    collect_frame(1'b0, 100, -1, 0, 8'h00, -1, -1, "t5_f1");
    collect_frame(1'b1, 100, 5, 20, 8'h5A, 2, 5, "t5_f2");
    collect_frame(1'b0, 100, -1, 0, 8'h00, -1, -1, "t5_f3");
    for (int i = 0; i < 20; i++) begin
      check("t5_no_extra_valid", 32'(out_valid), 32'd0);
      check("t5_no_extra_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end

    // Reset during row 1.
    drain();
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
    repeat (24) @(negedge clk);
    check("t6_in_row1", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_data", 32'(out_data), 32'h000);
    reset_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    collect_frame(1'b0, 100, -1, 0, 8'h00, -1, -1, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
